// File: rtl/axis_dot_acc.sv
// Streaming dot-accumulator: sums the signed lanes of each AXIS beat, accumulates over len beats, emits one result.
// Optional saturating accumulation is enabled with the AXIS_DOT_ACC_SAT_EN macro (default: wrapping addition, sat tied to 0).
module axis_dot_acc #(
  parameter int DATA_WIDTH = 64,
  parameter int ELEM_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ACC_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  sat,
  output logic [63:0]           probe,
  output logic [1:0]            dbg_state
);

  localparam int LANES = DATA_WIDTH / ELEM_WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // master side holds m_axis_tdata/m_axis_tvalid stable until it is taken.
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN, ST_OUT} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]          done_cnt_q, done_cnt_d;
  logic [ACC_WIDTH-1:0] lane_sum;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 p1_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [ACC_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 sat_q, sat_d;
  logic                 clamp;
  logic                 beat_ok;

  assign s_axis_tready = (state_q == ST_ACC) && (beat_cnt_q < len_q);
  assign beat_ok       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_WIDTH-ELEM_WIDTH){s_axis_tdata[i*ELEM_WIDTH+ELEM_WIDTH-1]}},
                             s_axis_tdata[i*ELEM_WIDTH +: ELEM_WIDTH]};
    end
  end

`ifdef AXIS_DOT_ACC_SAT_EN
  logic [ACC_WIDTH:0] wide_sum;
  // One guard bit detects signed overflow; clamp toward the overflow direction.
  always_comb begin
    wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {sum_q[ACC_WIDTH-1], sum_q};
    acc_next = wide_sum[ACC_WIDTH-1:0];
    clamp    = 1'b0;
    if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
      clamp    = 1'b1;
      acc_next = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_next = acc_q + sum_q;
  assign clamp    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    done_cnt_d = done_cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    if (p1_q) begin
      acc_d = acc_next;
      sat_d = sat_q | clamp;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = len;
          beat_cnt_d = '0;
          acc_d      = '0;
          sat_d      = 1'b0;
          if (len == '0) begin
            state_d    = ST_OUT;
            m_tdata_d  = '0;
            m_tvalid_d = 1'b1;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          if (beat_cnt_d == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last lane sum is still in stage 1; fold it straight into the result.
        state_d    = ST_OUT;
        m_tdata_d  = acc_next;
        m_tvalid_d = 1'b1;
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          state_d    = ST_IDLE;
          m_tvalid_d = 1'b0;
          done_cnt_d = done_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      done_cnt_q <= '0;
      sum_q      <= '0;
      p1_q       <= 1'b0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      done_cnt_q <= done_cnt_d;
      if (beat_ok) sum_q <= lane_sum;
      p1_q       <= beat_ok;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign sat           = sat_q;
  assign probe         = {done_cnt_q, 32'(beat_cnt_q)};
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_dot_acc.sv
// Bench for axis_dot_acc: a 32-bit and a 16-bit accumulator instance share one stimulus stream and
// are checked every cycle against an integer model, plus hand-computed result literals.
module tb_axis_dot_acc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;

  logic        busy, s_tready, m_tvalid, sat;
  logic [31:0] tdata32;
  logic [63:0] probe;
  logic [1:0]  dbg_state;
  logic        busy16, s_tready16, m_tvalid16, sat16;
  logic [15:0] tdata16;
  logic [63:0] probe16;
  logic [1:0]  dbg_state16;

  int n_vec = 0;
  int n_err = 0;

  axis_dot_acc u_dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .busy(busy),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(tdata32), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .sat(sat), .probe(probe), .dbg_state(dbg_state)
  );

  axis_dot_acc #(.ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .busy(busy16),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready16),
    .m_axis_tdata(tdata16), .m_axis_tvalid(m_tvalid16), .m_axis_tready(m_tready),
    .sat(sat16), .probe(probe16), .dbg_state(dbg_state16)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model: whole-vector arithmetic on plain integers
  function automatic longint lane_sum(input logic [63:0] d);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(d[i*8 +: 8]));
    return s;
  endfunction

  function automatic longint acc_step(input longint a, input longint b, input int w, inout bit s);
    longint r  = a + b;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
`ifdef AXIS_DOT_ACC_SAT_EN
    if (r > hi) begin r = hi; s = 1'b1; end
    else if (r < lo) begin r = lo; s = 1'b1; end
`else
    if (r > hi) r -= (longint'(1) <<< w);
    else if (r < lo) r += (longint'(1) <<< w);
`endif
    return r;
  endfunction

  bit          md_busy, md_acc, md_drain, md_out_valid, md_sat32, md_sat16;
  int          md_len, md_cnt;
  int unsigned md_done;
  longint      md_acc32, md_acc16, md_data32, md_data16;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_busy = 0; md_acc = 0; md_drain = 0; md_out_valid = 0; md_sat32 = 0; md_sat16 = 0;
      md_len = 0; md_cnt = 0; md_done = 0;
      md_acc32 = 0; md_acc16 = 0; md_data32 = 0; md_data16 = 0;
    end else if (md_out_valid && m_tready) begin
      md_out_valid = 0; md_busy = 0; md_done++;
    end else if (!md_busy && start) begin
      md_busy = 1; md_len = int'(len); md_cnt = 0;
      md_acc32 = 0; md_acc16 = 0; md_sat32 = 0; md_sat16 = 0;
      if (len == 0) begin
        md_out_valid = 1; md_data32 = 0; md_data16 = 0;
      end else begin
        md_acc = 1;
      end
    end else if (md_acc && s_tvalid) begin
      md_cnt++;
      md_acc32 = acc_step(md_acc32, lane_sum(s_tdata), 32, md_sat32);
      md_acc16 = acc_step(md_acc16, lane_sum(s_tdata), 16, md_sat16);
      if (md_cnt == md_len) begin md_acc = 0; md_drain = 1; end
    end else if (md_drain) begin
      md_drain = 0; md_out_valid = 1; md_data32 = md_acc32; md_data16 = md_acc16;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      check("s_tready", s_tready, md_acc);
      check("busy", busy, md_busy);
      check("m_tvalid", m_tvalid, md_out_valid);
      check("m_tdata", tdata32, md_data32[31:0]);
      check("probe", probe, {md_done[31:0], 16'h0, md_cnt[15:0]});
      check("m_tvalid16", m_tvalid16, md_out_valid);
      check("m_tdata16", tdata16, md_data16[15:0]);
      if (!md_acc && !md_drain) begin
        check("sat", sat, md_sat32);
        check("sat16", sat16, md_sat16);
      end
    end
  end

  // driver tasks; each is entered and left just after a rising edge
  task automatic do_start(input int l);
    start = 1'b1;
    len   = 16'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int   n   = 0;
    logic got = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = s_tready;
      @(posedge clk); #1;
      n++;
    end
    s_tvalid = 1'b0;
    check("beat_accepted", got, 1'b1);
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp, input bit use16,
                             input logic [15:0] exp16, input bit exp_sat16);
    int n = 0;
    while (m_tvalid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, m_tvalid, 1'b1);
    check({name, "_data"}, tdata32, exp);
    if (use16) begin
      check({name, "_data16"}, tdata16, exp16);
      check({name, "_sat16"}, sat16, exp_sat16);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_tready", s_tready, 1'b0);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", tdata32, 32'h0);
    check("rst_probe", probe, 64'h0);
    check("rst_state", dbg_state, 2'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: single beat of 0x01 lanes, latency two cycles after the handshake
    do_start(1);
    send_beat({8{8'h01}});
    @(negedge clk);
    check("t1_lat_early", m_tvalid, 1'b0);
    @(negedge clk);
    check("t1_lat", m_tvalid, 1'b1);
    check("t1_data", tdata32, 32'd8);
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    @(negedge clk);
    check("t1_done_cnt", probe[63:32], 32'd1);
    check("t1_tvalid_drop", m_tvalid, 1'b0);
    @(posedge clk); #1;

    // 2: negative lanes sign-extend
    do_start(4);
    for (int i = 0; i < 4; i++) send_beat({8{8'hFF}});
    wait_result("t2", 32'hFFFF_FFE0, 1'b1, 16'hFFE0, 1'b0);

    // 3: backpressure holds the result
    do_start(3);
    for (int i = 0; i < 3; i++) send_beat({8{8'h7F}});
    for (int i = 0; i < 10 && m_tvalid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_data", tdata32, 32'd3048);
      check("t3_hold_valid", m_tvalid, 1'b1);
      check("t3_hold_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    wait_result("t3", 32'd3048, 1'b0, 16'h0, 1'b0);

    // 4: gapped beats, stray starts and a new len are ignored
    do_start(2);
    do_start(7);
    send_beat({8{8'h02}});
    do_start(7);
    repeat (2) begin @(posedge clk); #1; end
    send_beat({8{8'h02}});
    s_tvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_no_ready", s_tready, 1'b0);
      check("t4_beats", probe[31:0], 32'd2);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    wait_result("t4", 32'd32, 1'b0, 16'h0, 1'b0);

    // 5: 40 beats of 0x7F overflow the 16-bit accumulator
    do_start(40);
    for (int i = 0; i < 40; i++) send_beat({8{8'h7F}});
`ifdef AXIS_DOT_ACC_SAT_EN
    wait_result("t5", 32'd40640, 1'b1, 16'h7FFF, 1'b1);
`else
    wait_result("t5", 32'd40640, 1'b1, 16'h9EC0, 1'b0);
`endif

    // 6: reset mid-vector discards it
    do_start(4);
    send_beat({8{8'h05}});
    send_beat({8{8'h05}});
    rstn = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_tready", s_tready, 1'b0);
    check("t6_tvalid", m_tvalid, 1'b0);
    check("t6_tdata", tdata32, 32'h0);
    check("t6_tdata16", tdata16, 16'h0);
    check("t6_probe", probe, 64'h0);
    check("t6_sat16", sat16, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_start(1);
    send_beat({8{8'h01}});
    wait_result("t6", 32'd8, 1'b1, 16'd8, 1'b0);
    @(negedge clk);
    check("t6_done_cnt", probe[63:32], 32'd1);
    @(posedge clk); #1;

    // 7: len of zero yields an immediate zero result
    do_start(0);
    @(negedge clk);
    check("t7_lat", m_tvalid, 1'b1);
    @(posedge clk); #1;
    wait_result("t7", 32'd0, 1'b1, 16'd0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
